// File: rtl/uart_pkg.sv
// Shared definitions for the oversampled UART receiver: FSM encoding,
// parity scheme constants and the sample-tick divisor helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Clocks per sample tick, never below one.
    function automatic int calc_div(input int clocks, input int baud, input int oversample);
        int d;
        d = clocks / (baud * oversample);
        return (d < 1) ? 1 : d;
    endfunction

endpackage

// File: rtl/baud_tick_generator.sv
// Free-running divider producing a one-cycle sample tick every DIV clocks;
// restart realigns the phase to the detected start edge.
module baud_tick_generator #(
    parameter int DIV = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (restart || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CW'(1);
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver: 2-of-3 mid-bit voting, optional parity,
// 1 or 2 stop bits, break handling, one-cycle result pulses.
module uart_rx_oversampled
    import uart_pkg::*;
#(
    parameter int CLOCKS_PER_SECOND = 100000000,
    parameter int BAUD_RATE         = 115200,
    parameter int OVERSAMPLE        = 16,
    parameter int DATA_BITS         = 8,
    parameter int PARITY_MODE       = 0,
    parameter int STOP_BITS         = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 serial_connection,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_error,
    output logic                 framing_error,
    output logic                 busy
);

    localparam int DIV = calc_div(CLOCKS_PER_SECOND, BAUD_RATE, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam logic [SW-1:0] VOTE_FIRST = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] VOTE_MID   = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] VOTE_LAST  = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] BIT_LAST   = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    DATA_LAST  = 4'(DATA_BITS - 1);
    localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);
    localparam logic          ODD_PARITY = (PARITY_MODE == PARITY_ODD);

    logic [1:0]           sync_ff;
    logic [1:0]           settle;
    logic                 line_high;
    logic                 rx;
    logic                 start_edge;
    rx_state_t            state, state_next;
    logic                 tick, restart;
    logic [SW-1:0]        sample_cnt;
    logic [1:0]           samples;
    logic                 vote, vote_point, bit_end;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 parity_bad, stop_bad;
    logic                 frame_done, frame_ferr;

    // Synchronizer idles high; settle keeps the reset value of the flops from
    // looking like line activity, so a frame needs a real high-to-low edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_ff   <= 2'b11;
            settle    <= 2'b00;
            line_high <= 1'b0;
        end else begin
            sync_ff   <= {sync_ff[0], serial_connection};
            settle    <= {settle[0], 1'b1};
            line_high <= settle[1] & rx;
        end
    end

    assign rx         = sync_ff[1];
    assign start_edge = settle[1] && line_high && !rx;

    baud_tick_generator #(.DIV(DIV)) u_tick (
        .clock   (clock),
        .reset   (reset),
        .restart (restart),
        .tick    (tick)
    );

    assign vote_point = tick && (sample_cnt == VOTE_LAST);
    assign bit_end    = tick && (sample_cnt == BIT_LAST);
    assign vote       = (samples[1] & samples[0]) | (samples[1] & rx) | (samples[0] & rx);
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    // NOTE: every signal driven here gets a default first, otherwise a latch is inferred.
    always_comb begin
        state_next = state;
        restart    = 1'b0;
        frame_done = 1'b0;
        frame_ferr = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_edge) begin
                    state_next = ST_START;
                    restart    = 1'b1;
                end
            end
            ST_START: begin
                if (vote_point && vote) state_next = ST_IDLE;
                else if (bit_end)       state_next = ST_DATA;
            end
            ST_DATA: begin
                if (bit_end && bit_cnt == DATA_LAST)
                    state_next = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
            end
            ST_PARITY: begin
                if (bit_end) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (vote_point && stop_cnt == STOP_LAST) begin
                    frame_done = 1'b1;
                    frame_ferr = stop_bad | !vote;
                    state_next = frame_ferr ? ST_WAIT_HIGH : ST_IDLE;
                end
            end
            ST_WAIT_HIGH: begin
                if (rx) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // The detect cycle counts as sample 0 of the start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sample_cnt    <= '0;
            samples       <= '0;
            bit_cnt       <= '0;
            stop_cnt      <= 1'b0;
            shift         <= '0;
            parity_bad    <= 1'b0;
            stop_bad      <= 1'b0;
            data          <= '0;
            valid         <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            valid         <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            if (restart) begin
                sample_cnt <= SW'(1);
                bit_cnt    <= '0;
                stop_cnt   <= 1'b0;
                parity_bad <= 1'b0;
                stop_bad   <= 1'b0;
            end else if (tick) begin
                sample_cnt <= (sample_cnt == BIT_LAST) ? '0 : sample_cnt + SW'(1);
                if (sample_cnt == VOTE_FIRST || sample_cnt == VOTE_MID)
                    samples <= {samples[0], rx};
                if (vote_point) begin
                    case (state)
                        ST_DATA:   shift      <= {vote, shift[DATA_BITS-1:1]};
                        ST_PARITY: parity_bad <= (vote != ((^shift) ^ ODD_PARITY));
                        ST_STOP:   stop_bad   <= stop_bad | !vote;
                        default: ;
                    endcase
                end
                if (bit_end && state == ST_DATA)
                    bit_cnt <= (bit_cnt == DATA_LAST) ? '0 : bit_cnt + 4'(1);
                if (bit_end && state == ST_STOP)
                    stop_cnt <= stop_cnt + 1'b1;
            end
            if (frame_done) begin
                data          <= shift;
                valid         <= !(parity_bad | frame_ferr);
                parity_error  <= parity_bad;
                framing_error <= frame_ferr;
            end
        end
    end

endmodule
